// File: rtl/match_pkg.sv
// Shared types and helpers for the multi-round match controller: state encoding, round winner
// codes, round-outcome decision and saturating counters.
package match_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StFight     = 3'd2,
    StRoundEnd  = 3'd3,
    StMatchP1   = 3'd4,
    StMatchP2   = 3'd5,
    StMatchDraw = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    WinNone = 2'd0,
    WinP1   = 2'd1,
    WinP2   = 2'd2,
    WinDraw = 2'd3
  } winner_t;

  // Health values are zero-extended to this width before comparison.
  localparam int unsigned HealthCmpW = 16;
  localparam logic [3:0]  CountMax   = 4'd15;

  // Covers both KO (a zero health always loses to a non-zero one) and timeout decisions.
  function automatic winner_t round_outcome(input logic [HealthCmpW-1:0] p1,
                                            input logic [HealthCmpW-1:0] p2);
    if (p1 == p2) begin
      return WinDraw;
    end else if (p1 > p2) begin
      return WinP1;
    end else begin
      return WinP2;
    end
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == CountMax) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sec_ticker.sv
// Game-second divider: emits a one-cycle tick every TICK_DIV enabled cycles. A synchronous clear
// restarts the count so the first second after a clear is always full length.
module sec_ticker #(
  parameter int unsigned TICK_DIV = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned    CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntOne;
    end
  end

  // Independent of clear_i: the clear is derived from transitions that this tick triggers.
  assign tick_o = en_i && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Best-of-N fight match controller: countdown, timed fight, round scoring, match result.
// Optional pause feature enabled by defining GAME_PAUSE_EN.
module match_controller
  import match_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 60,
  parameter int unsigned COUNTDOWN_S   = 3,
  parameter int unsigned ROUND_TIME_S  = 99,
  parameter int unsigned ROUND_END_S   = 2,
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned HEALTH_W      = 3,
  parameter int unsigned TIMER_W       = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic [HEALTH_W-1:0] p1_health,
  input  logic [HEALTH_W-1:0] p2_health,
  output logic [2:0]          game_state,
  output logic [TIMER_W-1:0]  timer,
  output logic [3:0]          round_num,
  output logic [3:0]          p1_rounds,
  output logic [3:0]          p2_rounds,
  output logic [1:0]          round_winner,
  output logic                paused
);

  localparam logic [TIMER_W-1:0] TimerOne      = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] CountdownLoad = TIMER_W'(COUNTDOWN_S);
  localparam logic [TIMER_W-1:0] FightLoad     = TIMER_W'(ROUND_TIME_S);
  localparam logic [TIMER_W-1:0] RoundEndLoad  = TIMER_W'(ROUND_END_S);
  localparam logic [3:0]         WinTarget     = 4'(ROUNDS_TO_WIN);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           round_num_q, round_num_d;
  logic [3:0]           p1_rounds_q, p1_rounds_d;
  logic [3:0]           p2_rounds_q, p2_rounds_d;
  winner_t              round_winner_q, round_winner_d;
  logic                 start_q, start_d;
  logic                 start_armed_q, start_armed_d;
  logic                 paused_q;

  logic    tick;
  logic    start_edge;
  logic    expire;
  logic    ko;
  winner_t outcome;

  // Armed only once start has been seen low, so a key held through reset is not a press.
  assign start_d       = start;
  assign start_armed_d = start_armed_q | ~start;
  assign start_edge    = start & ~start_q & start_armed_q;

  sec_ticker #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_ticker (
    .clk    (clk),
    .reset  (reset),
    .clear_i(state_d != state_q),
    .en_i   (~paused_q),
    .tick_o (tick)
  );

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    round_num_d    = round_num_q;
    p1_rounds_d    = p1_rounds_q;
    p2_rounds_d    = p2_rounds_q;
    round_winner_d = round_winner_q;

    outcome = round_outcome(HealthCmpW'(p1_health), HealthCmpW'(p2_health));
    ko      = (p1_health == '0) || (p2_health == '0);
    expire  = tick && (timer_q == TimerOne);

    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (start_edge) begin
          state_d        = StCountdown;
          timer_d        = CountdownLoad;
          round_num_d    = 4'd1;
          p1_rounds_d    = '0;
          p2_rounds_d    = '0;
          round_winner_d = WinNone;
        end
      end
      StCountdown: begin
        if (expire) begin
          state_d = StFight;
          timer_d = FightLoad;
        end else if (tick) begin
          timer_d = timer_q - TimerOne;
        end
      end
      StFight: begin
        // KO and timeout share one decision; a KO simply does not wait for the tick.
        if (!paused_q && (ko || expire)) begin
          state_d        = StRoundEnd;
          timer_d        = RoundEndLoad;
          round_winner_d = outcome;
          if (outcome != WinP2) p1_rounds_d = sat_inc(p1_rounds_q);
          if (outcome != WinP1) p2_rounds_d = sat_inc(p2_rounds_q);
        end else if (tick) begin
          timer_d = timer_q - TimerOne;
        end
      end
      StRoundEnd: begin
        if (expire) begin
          timer_d = '0;
          if ((p1_rounds_q >= WinTarget) && (p2_rounds_q >= WinTarget)) begin
            state_d = StMatchDraw;
          end else if (p1_rounds_q >= WinTarget) begin
            state_d = StMatchP1;
          end else if (p2_rounds_q >= WinTarget) begin
            state_d = StMatchP2;
          end else begin
            state_d        = StCountdown;
            timer_d        = CountdownLoad;
            round_num_d    = sat_inc(round_num_q);
            round_winner_d = WinNone;
          end
        end else if (tick) begin
          timer_d = timer_q - TimerOne;
        end
      end
      StMatchP1, StMatchP2, StMatchDraw: begin
        timer_d = '0;
        if (start_edge) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

`ifdef GAME_PAUSE_EN
  logic pause_q, pause_d;
  logic paused_d;

  assign pause_d = pause;

  always_comb begin
    paused_d = paused_q;
    if ((state_q == StCountdown || state_q == StFight) && pause && !pause_q) begin
      paused_d = ~paused_q;
    end
    if (state_d != state_q) begin
      paused_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      pause_q  <= pause_d;
      paused_q <= paused_d;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused_q     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      round_num_q    <= '0;
      p1_rounds_q    <= '0;
      p2_rounds_q    <= '0;
      round_winner_q <= WinNone;
      start_q        <= 1'b0;
      start_armed_q  <= ~start;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      round_num_q    <= round_num_d;
      p1_rounds_q    <= p1_rounds_d;
      p2_rounds_q    <= p2_rounds_d;
      round_winner_q <= round_winner_d;
      start_q        <= start_d;
      start_armed_q  <= start_armed_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    game_state   = state_q;
    timer        = timer_q;
    round_num    = round_num_q;
    p1_rounds    = p1_rounds_q;
    p2_rounds    = p2_rounds_q;
    round_winner = round_winner_q;
    paused       = paused_q;
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a short tick (4 cycles/second) and 5-second rounds.
module tb_match_controller;

  localparam int S_IDLE = 0, S_CD = 1, S_FIGHT = 2, S_REND = 3;
  localparam int S_MP1 = 4, S_MP2 = 5, S_MDRAW = 6;

  logic       clk = 1'b0;
  logic       reset, start, pause;
  logic [2:0] p1_health, p2_health;
  logic [2:0] game_state;
  logic [6:0] timer;
  logic [3:0] round_num, p1_rounds, p2_rounds;
  logic [1:0] round_winner;
  logic       paused;

  int n_cmp = 0;
  int n_err = 0;

  match_controller #(
    .TICK_DIV     (4),
    .COUNTDOWN_S  (3),
    .ROUND_TIME_S (5),
    .ROUND_END_S  (2),
    .ROUNDS_TO_WIN(2),
    .HEALTH_W     (3),
    .TIMER_W      (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .p1_health   (p1_health),
    .p2_health   (p2_health),
    .game_state  (game_state),
    .timer       (timer),
    .round_num   (round_num),
    .p1_rounds   (p1_rounds),
    .p2_rounds   (p2_rounds),
    .round_winner(round_winner),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    p1_health = 3'd3; p2_health = 3'd3;
    step(2);
    chk("rst_state", game_state, S_IDLE);
    chk("rst_timer", timer, 0);
    chk("rst_round", round_num, 0);
    chk("rst_p1", p1_rounds, 0);
    chk("rst_p2", p2_rounds, 0);
    chk("rst_winner", round_winner, 0);
    chk("rst_paused", paused, 0);
    reset = 1'b0;
    step(2);
    chk("idle_hold", game_state, S_IDLE);

    // Round 1: countdown 3,2,1 then fight
    press_start();
    chk("cd_state", game_state, S_CD);
    chk("cd_t3", timer, 3);
    chk("cd_round", round_num, 1);
    step(3);
    chk("cd_t3_late", timer, 3);
    step(1);
    chk("cd_t2", timer, 2);
    step(4);
    chk("cd_t1", timer, 1);
    step(3);
    chk("cd_still", game_state, S_CD);
    step(1);
    chk("fight_state", game_state, S_FIGHT);
    chk("fight_t5", timer, 5);
    chk("fight_round", round_num, 1);

    // P2 KO
    p2_health = 3'd0;
    step(1);
    p2_health = 3'd3;
    chk("ko_state", game_state, S_REND);
    chk("ko_winner", round_winner, 1);
    chk("ko_p1", p1_rounds, 1);
    chk("ko_p2", p2_rounds, 0);
    chk("rend_t2", timer, 2);
    step(7);
    chk("rend_hold", game_state, S_REND);
    chk("rend_t1", timer, 1);
    step(1);
    chk("r2_state", game_state, S_CD);
    chk("r2_round", round_num, 2);
    chk("r2_winner_clr", round_winner, 0);
    chk("r2_t3", timer, 3);

    // Round 2: P1 wins again -> match
    step(12);
    chk("r2_fight", game_state, S_FIGHT);
    p2_health = 3'd0;
    step(1);
    p2_health = 3'd3;
    chk("r2_p1", p1_rounds, 2);
    step(8);
    chk("mp1_state", game_state, S_MP1);
    chk("mp1_timer", timer, 0);
    step(3);
    chk("mp1_hold", game_state, S_MP1);
    press_start();
    chk("back_idle", game_state, S_IDLE);
    chk("idle_keeps_p1", p1_rounds, 2);
    step(1);
    press_start();
    chk("new_cd", game_state, S_CD);
    chk("new_p1_clr", p1_rounds, 0);
    chk("new_round", round_num, 1);

    // Two timeout draws -> match draw
    step(12);
    chk("d1_fight", game_state, S_FIGHT);
    step(19);
    chk("d1_t1", timer, 1);
    chk("d1_still", game_state, S_FIGHT);
    step(1);
    chk("d1_rend", game_state, S_REND);
    chk("d1_winner", round_winner, 3);
    chk("d1_p1", p1_rounds, 1);
    chk("d1_p2", p2_rounds, 1);
    step(8);
    chk("d2_cd", game_state, S_CD);
    step(12);
    step(20);
    chk("d2_rend", game_state, S_REND);
    chk("d2_winner", round_winner, 3);
    step(8);
    chk("mdraw_state", game_state, S_MDRAW);
    chk("mdraw_p1", p1_rounds, 2);
    chk("mdraw_p2", p2_rounds, 2);
    chk("mdraw_round", round_num, 2);

    // KO on the same cycle as timeout
    press_start();
    chk("idle2", game_state, S_IDLE);
    step(1);
    press_start();
    step(12);
    chk("k_fight", game_state, S_FIGHT);
    step(19);
    chk("k_t1", timer, 1);
    p1_health = 3'd0; p2_health = 3'd2;
    step(1);
    p1_health = 3'd3; p2_health = 3'd3;
    chk("k_rend", game_state, S_REND);
    chk("k_winner", round_winner, 2);
    chk("k_p1", p1_rounds, 0);
    chk("k_p2", p2_rounds, 1);

    // Round 2 with a pause request mid-fight
    step(8);
    step(12);
    chk("p_fight", game_state, S_FIGHT);
    step(4);
    chk("p_t4", timer, 4);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
`ifdef GAME_PAUSE_EN
    chk("p_paused", paused, 1);
    p1_health = 3'd0;
    step(20);
    chk("p_frozen_state", game_state, S_FIGHT);
    chk("p_frozen_t", timer, 4);
    chk("p_still", paused, 1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk("p_resumed", paused, 0);
    chk("p_resume_state", game_state, S_FIGHT);
    step(1);
`else
    chk("p_ignored", paused, 0);
    chk("p_t4_hold", timer, 4);
    p1_health = 3'd0;
    step(1);
`endif
    p1_health = 3'd3;
    chk("p_ko_state", game_state, S_REND);
    chk("p_ko_winner", round_winner, 2);
    chk("p_ko_p2", p2_rounds, 2);
    step(8);
    chk("mp2_state", game_state, S_MP2);

    // Start held through reset release is not a press
    start = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    chk("held_idle", game_state, S_IDLE);
    start = 1'b0;
    step(1);
    press_start();
    chk("repress_cd", game_state, S_CD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
